// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calc_sequencer block: FSM encoding, timeout error byte
// and default data width.
package calc_sequencer_pkg;

   localparam int unsigned DEF_DATA_W = 8;

   // Byte placed at the top of the result when the ALU never answers
   localparam logic [7:0] TIMEOUT_BYTE = 8'hEE;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ALU = 2'd2,
      SEND     = 2'd3
   } state_t;

endpackage

// File: rtl/calc_tx_serializer.sv
// Result shift register and byte counter driving the UART transmitter,
// most-significant byte first, over a valid/ready byte interface.
module calc_tx_serializer #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned RES_BYTES = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          load,
   input  logic [DATA_W*RES_BYTES-1:0]   load_data,
   input  logic                          tx_ready,
   output logic                          tx_valid,
   output logic [DATA_W-1:0]             tx_data,
   output logic                          last_xfer_c
);

   localparam int unsigned RES_W = DATA_W * RES_BYTES;
   localparam int unsigned CNT_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

   logic [RES_W-1:0] sh_q;
   logic [CNT_W-1:0] cnt_q;
   logic             xfer_c;

   assign xfer_c      = tx_valid && tx_ready;
   assign last_xfer_c = xfer_c && (cnt_q == '0);
   assign tx_data     = sh_q[RES_W-1 -: DATA_W];

   // Load the whole result, then shift one byte per accepted transfer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sh_q     <= '0;
         cnt_q    <= '0;
         tx_valid <= 1'b0;
      end else if (load) begin
         sh_q     <= load_data;
         cnt_q    <= CNT_W'(RES_BYTES - 1);
         tx_valid <= 1'b1;
      end else if (xfer_c) begin
         if (cnt_q != '0) begin
            sh_q  <= sh_q << DATA_W;
            cnt_q <= cnt_q - CNT_W'(1);
         end else begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Command-frame sequencer: captures a frame, launches the ALU, serialises the result.
// Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer
   import calc_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned RES_BYTES      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          frame_valid,
   input  logic [DATA_W-1:0]             frame_op,
   input  logic [DATA_W-1:0]             frame_a,
   input  logic [DATA_W-1:0]             frame_b,
   output logic                          alu_start,
   output logic [DATA_W-1:0]             alu_op,
   output logic [DATA_W-1:0]             alu_a,
   output logic [DATA_W-1:0]             alu_b,
   input  logic                          alu_done,
   input  logic [DATA_W*RES_BYTES-1:0]   alu_result,
   output logic                          tx_valid,
   output logic [DATA_W-1:0]             tx_data,
   input  logic                          tx_ready,
   output logic                          busy,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int unsigned RES_W = DATA_W * RES_BYTES;
   localparam logic [RES_W-1:0] TO_WORD =
      RES_W'(DATA_W'(TIMEOUT_BYTE)) << (RES_W - DATA_W);

   if (RES_BYTES < 1 || RES_BYTES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("calc_sequencer: illegal RES_BYTES or TIMEOUT_CYCLES");
   end

   state_t           state_q, state_d;
   logic             load_c;
   logic [RES_W-1:0] load_data_c;
   logic             last_xfer_c;
   logic             timeout_c;

`ifdef CALC_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_q;

   assign timeout_c = (state_q == WAIT_ALU) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counts cycles spent in WAIT_ALU; held at zero elsewhere
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         to_cnt_q <= '0;
      end else if (state_q != WAIT_ALU) begin
         to_cnt_q <= '0;
      end else if (!timeout_c) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Next-state and serializer load decode
   always_comb begin
      state_d     = state_q;
      load_c      = 1'b0;
      load_data_c = alu_result;
      case (state_q)
         IDLE:     if (frame_valid) state_d = ISSUE;
         ISSUE:    state_d = WAIT_ALU;
         WAIT_ALU: begin
            if (alu_done) begin
               load_c  = 1'b1;
               state_d = SEND;
            end else if (timeout_c) begin
               load_c      = 1'b1;
               load_data_c = TO_WORD;
               state_d     = SEND;
            end
         end
         SEND:     if (last_xfer_c) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         alu_start <= 1'b0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_start <= (state_d == ISSUE);
         busy      <= (state_d != IDLE);
         if (state_q == IDLE && frame_valid) begin
            alu_op <= frame_op;
            alu_a  <= frame_a;
            alu_b  <= frame_b;
         end
         // A dropped frame takes priority over a clear in the same cycle
         if (frame_valid && state_q != IDLE) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   calc_tx_serializer #(
      .DATA_W    (DATA_W),
      .RES_BYTES (RES_BYTES)
   ) u_ser (
      .clock       (clock),
      .reset       (reset),
      .load        (load_c),
      .load_data   (load_data_c),
      .tx_ready    (tx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .last_xfer_c (last_xfer_c)
   );

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer (RES_BYTES=2 main instance, RES_BYTES=1 variant).
module tb_calc_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        frame_valid = 1'b0;
   logic [7:0]  frame_op = '0, frame_a = '0, frame_b = '0;
   logic        alu_start;
   logic [7:0]  alu_op, alu_a, alu_b;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = '0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        busy, overrun;
   logic        err_clr = 1'b0;

   logic        frame_valid_1 = 1'b0;
   logic        alu_start_1;
   logic [7:0]  alu_op_1, alu_a_1, alu_b_1;
   logic        alu_done_1 = 1'b0;
   logic [7:0]  alu_result_1 = '0;
   logic        tx_valid_1;
   logic [7:0]  tx_data_1;
   logic        tx_ready_1 = 1'b1;
   logic        busy_1, overrun_1;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   calc_sequencer #(.DATA_W(8), .RES_BYTES(2), .TIMEOUT_CYCLES(10)) dut (
      .clock(clock), .reset(reset), .frame_valid(frame_valid),
      .frame_op(frame_op), .frame_a(frame_a), .frame_b(frame_b),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .overrun(overrun), .err_clr(err_clr)
   );

   calc_sequencer #(.DATA_W(8), .RES_BYTES(1), .TIMEOUT_CYCLES(10)) dut1 (
      .clock(clock), .reset(reset), .frame_valid(frame_valid_1),
      .frame_op(frame_op), .frame_a(frame_a), .frame_b(frame_b),
      .alu_start(alu_start_1), .alu_op(alu_op_1), .alu_a(alu_a_1), .alu_b(alu_b_1),
      .alu_done(alu_done_1), .alu_result(alu_result_1),
      .tx_valid(tx_valid_1), .tx_data(tx_data_1), .tx_ready(tx_ready_1),
      .busy(busy_1), .overrun(overrun_1), .err_clr(err_clr)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      frame_op = op; frame_a = a; frame_b = b; frame_valid = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      checks++;
      if ({alu_start, tx_valid, busy, overrun} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {alu_start, tx_valid, busy, overrun});
      end
      checks++;
      if ({alu_op, alu_a, alu_b, tx_data} !== 32'h0) begin
         errors++; $display("FAIL reset_data: got %h want 00000000", {alu_op, alu_a, alu_b, tx_data});
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      set_frame(8'h01, 8'h12, 8'h34);
      tick();
      frame_valid = 1'b0;
      checks++;
      if ({alu_start, busy} !== 2'b11) begin
         errors++; $display("FAIL basic_start: got %b want 11", {alu_start, busy});
      end
      checks++;
      if ({alu_op, alu_a, alu_b} !== 24'h011234) begin
         errors++; $display("FAIL basic_operands: got %h want 011234", {alu_op, alu_a, alu_b});
      end
      tick();
      checks++;
      if (alu_start !== 1'b0) begin
         errors++; $display("FAIL basic_start_pulse: got %b want 0", alu_start);
      end
      tick();
      alu_done = 1'b1; alu_result = 16'h0046;
      tick();
      alu_done = 1'b0;
      checks++;
      if ({tx_valid, tx_data} !== 9'h100) begin
         errors++; $display("FAIL basic_byte0: got %h want 100", {tx_valid, tx_data});
      end
      tick();
      checks++;
      if ({tx_valid, tx_data} !== 9'h146) begin
         errors++; $display("FAIL basic_byte1: got %h want 146", {tx_valid, tx_data});
      end
      tick();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL basic_idle: got %b want 00", {tx_valid, busy});
      end
   endtask

   task automatic test_alu_done_ignored();
      alu_done = 1'b1; alu_result = 16'hDEAD;
      tick();
      alu_done = 1'b0;
      tick();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL stray_done: got %b want 00", {tx_valid, busy});
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      tx_ready = 1'b0;
      set_frame(8'h03, 8'h01, 8'h02);
      tick();
      frame_valid = 1'b0;
      tick();
      alu_done = 1'b1; alu_result = 16'hBEEF;
      tick();
      alu_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if ({tx_valid, tx_data} !== 9'h1BE) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || {tx_valid, tx_data} !== 9'h1BE) begin
         errors++; $display("FAIL bp_hold: got %h (%0d bad cycles) want 1be", {tx_valid, tx_data}, bad);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      checks++;
      if ({tx_valid, tx_data} !== 9'h1EF) begin
         errors++; $display("FAIL bp_one_xfer: got %h want 1ef", {tx_valid, tx_data});
      end
      tick(); tick();
      checks++;
      if ({tx_valid, tx_data, busy} !== 10'b1_1110_1111_1) begin
         errors++; $display("FAIL bp_wait_second: got %b want 1111011111", {tx_valid, tx_data, busy});
      end
      tx_ready = 1'b1;
      tick();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL bp_done: got %b want 00", {tx_valid, busy});
      end
   endtask

   task automatic test_overrun();
      set_frame(8'h05, 8'h11, 8'h22);
      tick();
      frame_valid = 1'b0;
      tick();
      set_frame(8'h02, 8'hFF, 8'hFF);
      tick();
      frame_valid = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++; $display("FAIL ovr_set: got %b want 1", overrun);
      end
      checks++;
      if ({alu_op, alu_a, alu_b} !== 24'h051122) begin
         errors++; $display("FAIL ovr_operands: got %h want 051122", {alu_op, alu_a, alu_b});
      end
      err_clr = 1'b1;
      tick();
      checks++;
      if (overrun !== 1'b0) begin
         errors++; $display("FAIL ovr_clear: got %b want 0", overrun);
      end
      set_frame(8'h02, 8'hFF, 8'hFF);
      tick();
      frame_valid = 1'b0; err_clr = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++; $display("FAIL ovr_set_wins: got %b want 1", overrun);
      end
      err_clr = 1'b1;
      alu_done = 1'b1; alu_result = 16'h1234;
      tick();
      err_clr = 1'b0; alu_done = 1'b0;
      tick(); tick();
      checks++;
      if ({busy, overrun, tx_valid} !== 3'b000) begin
         errors++; $display("FAIL ovr_finish: got %b want 000", {busy, overrun, tx_valid});
      end
   endtask

   task automatic test_back_to_back();
      set_frame(8'h0A, 8'h21, 8'h43);
      tick();
      frame_valid = 1'b0;
      tick();
      alu_done = 1'b1; alu_result = 16'hCAFE;
      tick();
      alu_done = 1'b0;
      tick();
      checks++;
      if ({tx_valid, tx_data} !== 9'h1FE) begin
         errors++; $display("FAIL b2b_byte1: got %h want 1fe", {tx_valid, tx_data});
      end
      set_frame(8'h0B, 8'h55, 8'h66);
      tick();
      checks++;
      if ({busy, overrun, alu_a} !== 10'b0_1_0010_0001) begin
         errors++; $display("FAIL b2b_dropped: got %b want 0100100001", {busy, overrun, alu_a});
      end
      tick();
      frame_valid = 1'b0;
      checks++;
      if ({alu_start, alu_a, alu_b} !== 17'h1_5566) begin
         errors++; $display("FAIL b2b_accept: got %h want 15566", {alu_start, alu_a, alu_b});
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      alu_done = 1'b1; alu_result = 16'h0000;
      tick();
      alu_done = 1'b0;
      tick(); tick();
      checks++;
      if ({busy, overrun} !== 2'b00) begin
         errors++; $display("FAIL b2b_finish: got %b want 00", {busy, overrun});
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      set_frame(8'h07, 8'h01, 8'h01);
      tick();
      frame_valid = 1'b0;
      tick();
      alu_done = 1'b1; alu_result = 16'hA5C3;
      tick();
      alu_done = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL rst_mid_async: got %b want 00", {tx_valid, busy});
      end
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (tx_valid !== 1'b0) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL rst_mid_no_byte: got %0d tx cycles want 0", seen);
      end
      set_frame(8'h0C, 8'h0D, 8'h0E);
      tick();
      frame_valid = 1'b0;
      checks++;
      if ({alu_start, alu_op, alu_a, alu_b} !== 25'h10C0D0E) begin
         errors++; $display("FAIL rst_mid_next: got %h want 10c0d0e", {alu_start, alu_op, alu_a, alu_b});
      end
      tick();
      alu_done = 1'b1; alu_result = 16'h0102;
      tick();
      alu_done = 1'b0;
      checks++;
      if ({tx_valid, tx_data} !== 9'h101) begin
         errors++; $display("FAIL rst_mid_byte0: got %h want 101", {tx_valid, tx_data});
      end
      tick();
      checks++;
      if ({tx_valid, tx_data} !== 9'h102) begin
         errors++; $display("FAIL rst_mid_byte1: got %h want 102", {tx_valid, tx_data});
      end
      tick();
   endtask

   task automatic test_width_one();
      frame_op = 8'h04; frame_a = 8'h3D; frame_b = 8'h02; frame_valid_1 = 1'b1;
      tick();
      frame_valid_1 = 1'b0;
      tick();
      alu_done_1 = 1'b1; alu_result_1 = 8'h7A;
      tick();
      alu_done_1 = 1'b0;
      checks++;
      if ({tx_valid_1, tx_data_1} !== 9'h17A) begin
         errors++; $display("FAIL w1_byte: got %h want 17a", {tx_valid_1, tx_data_1});
      end
      tick();
      checks++;
      if ({tx_valid_1, busy_1} !== 2'b00) begin
         errors++; $display("FAIL w1_idle: got %b want 00", {tx_valid_1, busy_1});
      end
   endtask

`ifdef CALC_TIMEOUT_EN
   task automatic test_timeout();
      set_frame(8'h06, 8'h00, 8'h00);
      tick();
      frame_valid = 1'b0;
      tick();
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if ({tx_valid, busy} !== 2'b01) begin
         errors++; $display("FAIL to_waiting: got %b want 01", {tx_valid, busy});
      end
      tick();
      checks++;
      if ({tx_valid, tx_data} !== 9'h1EE) begin
         errors++; $display("FAIL to_byte0: got %h want 1ee", {tx_valid, tx_data});
      end
      tick();
      checks++;
      if ({tx_valid, tx_data} !== 9'h100) begin
         errors++; $display("FAIL to_byte1: got %h want 100", {tx_valid, tx_data});
      end
      tick();
      set_frame(8'h06, 8'h00, 8'h00);
      tick();
      frame_valid = 1'b0;
      tick();
      for (int i = 0; i < 9; i++) tick();
      alu_done = 1'b1; alu_result = 16'h5566;
      tick();
      alu_done = 1'b0;
      checks++;
      if ({tx_valid, tx_data} !== 9'h155) begin
         errors++; $display("FAIL to_done_wins: got %h want 155", {tx_valid, tx_data});
      end
      tick(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_alu_done_ignored();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_width_one();
`ifdef CALC_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Sequences one arithmetic transaction per received command frame (opcode, operand A, operand B).
- Takes the assembled frame from the UART receive-side frame assembler and launches the shared ALU with a start/done handshake.
- Serialises the ALU result, most-significant byte first, to the UART transmitter over a valid/ready byte interface.
- Flags frames that arrive while a transaction is in flight.

Parameters:
- DATA_W, 8: width of opcode, operands and each transmitted byte.
- RES_BYTES, 2: number of bytes in the ALU result. The result width is DATA_W*RES_BYTES. Legal range is 1..4.
- TIMEOUT_CYCLES, 255: ALU watchdog limit in clock cycles. Used only when CALC_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle pulse: frame_op, frame_a and frame_b are valid.
- frame_op  in  DATA_W  opcode byte.
- frame_a  in  DATA_W  operand A.
- frame_b  in  DATA_W  operand B.
- alu_start  out  1  one-cycle pulse launching the ALU.
- alu_op  out  DATA_W  registered opcode, held from frame capture until the next capture.
- alu_a  out  DATA_W  registered operand A, held the same way.
- alu_b  out  DATA_W  registered operand B, held the same way.
- alu_done  in  1  one-cycle pulse: alu_result is valid.
- alu_result  in  DATA_W*RES_BYTES  ALU result.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  DATA_W  byte to transmit.
- tx_ready  in  1  transmitter accepts the byte on an edge where tx_valid=1 and tx_ready=1.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky flag: a frame was dropped.
- err_clr  in  1  clears overrun.

Behaviour:
- Reset (async, active-low). State goes to IDLE and all outputs go to 0: alu_start, alu_op, alu_a, alu_b, tx_valid, tx_data, busy, overrun. The result shift register and byte counter clear. Reset asserted mid-transaction aborts it immediately with no further tx bytes.
- IDLE:
  - frame_valid=1 → capture op/A/B into alu_op/alu_a/alu_b; next state ISSUE.
- ISSUE:
  - alu_start=1 for exactly this cycle; next state WAIT_ALU.
  - alu_start therefore rises on the edge after the frame_valid edge (latency 1).
- WAIT_ALU:
  - alu_done=1 → latch alu_result into the shift register; byte counter = RES_BYTES-1; next state SEND.
  - alu_done outside WAIT_ALU is ignored.
- SEND:
  - tx_valid=1; tx_data = most-significant byte of the shift register.
  - tx_valid and tx_data stay stable until the transfer edge (tx_valid=1 and tx_ready=1).
  - On the transfer edge with counter≠0: shift left by DATA_W and decrement the counter; tx_valid stays 1 with the next byte on the following cycle.
  - On the transfer edge with counter=0: tx_valid→0; next state IDLE.
- Throughput: with tx_ready held high, the RES_BYTES bytes go out on consecutive cycles.
- Overrun:
  - frame_valid=1 in any state other than IDLE → the frame is discarded, the captured operands are unchanged, and overrun←1.
  - err_clr=1 → overrun←0. If err_clr and a new overrun occur in the same cycle, set wins.
- Back-to-back: frame_valid in the same cycle the last byte transfers is dropped (state is still SEND). A frame is accepted from the first IDLE cycle onward.
- Opcode is passed through uninterpreted; the ALU owns opcode decoding.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_ALU, reset on entry.
  - If it reaches TIMEOUT_CYCLES with no alu_done, the shift register loads {0xEE, zeros...} (0xEE in the top byte) and the state goes to SEND. The transmitted bytes are 0xEE followed by RES_BYTES-1 zero bytes.
  - alu_done arriving in the same cycle as the timeout wins, and the real result is sent.
  - A later stray alu_done is ignored.
- Undefined: no counter; WAIT_ALU waits indefinitely.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT_ALU=2, SEND=3;
  - the timeout error byte 0xEE;
  - DATA_W default.
- One natural sub-module: calc_tx_serializer, containing the shift register, byte counter and valid/ready logic for the SEND stage. The FSM stays in calc_sequencer.

Test Plan:
- Basic transaction, RES_BYTES=2, tx_ready held high:
  - Stimulus: frame op=0x01, A=0x12, B=0x34; alu_done returns 0x0046 three cycles after alu_start.
  - Response: alu_start one cycle after frame_valid; alu_op/a/b = 01/12/34; tx bytes 0x00 then 0x46 on consecutive cycles; busy falls after the second transfer.
- Backpressure:
  - Stimulus: result 0xBEEF; tx_ready low for 5 cycles, then a single high pulse, then low again.
  - Response: tx_data holds 0xBE stable while tx_ready is low; exactly one transfer occurs; 0xEF follows only on the next tx_ready pulse.
- Overrun:
  - Stimulus: second frame (op=0x02, A=0xFF, B=0xFF) during WAIT_ALU.
  - Response: overrun=1; alu_a stays at the first frame's value; err_clr pulse → overrun=0; err_clr together with another dropped frame → overrun stays 1.
- Reset mid-transaction:
  - Stimulus: reset low during SEND after the first byte transfers.
  - Response: tx_valid=0 and busy=0 immediately; no second byte after release; the next frame is processed normally.
- Timeout (CALC_TIMEOUT_EN, TIMEOUT_CYCLES=10):
  - Stimulus: no alu_done.
  - Response: after 10 cycles in WAIT_ALU, tx bytes are 0xEE, 0x00.
  - Repeat with alu_done on cycle 10: the real result is sent.
- Width variant RES_BYTES=1:
  - Stimulus: result 0x7A.
  - Response: single byte 0x7A transmitted; then IDLE.
